grade_evaluator: RTL and testbench

Sequential, parametrised student-result evaluator. It accepts NUM_SECT section grades one per cycle over a valid/ready stream and accumulates the total. It then classifies the result as failed, passed or award_scholarship against configurable thresholds and a per-section minimum, and presents the registered result over an output valid/ready handshake. It also keeps saturating statistics counters for reporting.

---
 rtl/grade_evaluator.sv | 151 +++++++++++++++
 tb/tb_grade_evaluator.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/grade_evaluator.sv
// Collects NUM_SECT section grades, classifies the student total and hands the
// result out over valid/ready, with saturating statistics for delivered results.
module grade_evaluator #(
    parameter int GRADE_W      = 8,
    parameter int NUM_SECT     = 4,
    parameter int PASS_THRESH  = 100,
    parameter int AWARD_THRESH = 200,
    parameter int MIN_SECT     = 0,
    parameter int CNT_W        = 16,
    localparam int SUM_W = (NUM_SECT > 1) ? GRADE_W + $clog2(NUM_SECT) : GRADE_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [GRADE_W-1:0] in_grade,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SUM_W-1:0]   out_total,
    output logic               failed,
    output logic               passed,
    output logic               award_scholarship,
    input  logic               stat_clear,
    output logic [CNT_W-1:0]   stat_students,
    output logic [CNT_W-1:0]   stat_passed,
    output logic [CNT_W-1:0]   stat_awards
);

    // state  | meaning
    // IDLE   | waiting for the first grade of a student
    // ACCUM  | summing the remaining grades
    // RESULT | classified result presented, waiting for out_ready

    localparam int CW = $clog2(NUM_SECT + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, RESULT} state_t;

    state_t            state, state_next;
    logic [CW-1:0]     sect_cnt;
    logic [SUM_W-1:0]  acc;
    logic              low_flag;

    logic              grade_xfer;
    logic              out_xfer;
    logic              last_grade;
    logic [SUM_W-1:0]  acc_next;
    logic              low_next;
    logic              fail_next;
    logic              award_next;

    assign grade_xfer = in_valid & in_ready;
    assign out_xfer   = out_valid & out_ready;
    // sect_cnt is zero in IDLE, so one compare covers NUM_SECT = 1 as well
    assign last_grade = (sect_cnt == CW'(NUM_SECT - 1));
    assign acc_next   = acc + SUM_W'(in_grade);
    assign low_next   = low_flag | (int'(in_grade) < MIN_SECT);
    assign fail_next  = (int'(acc_next) < PASS_THRESH) | low_next;
    assign award_next = ~fail_next & (int'(acc_next) >= AWARD_THRESH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, ACCUM: begin
                if (grade_xfer) begin
                    state_next = last_grade ? RESULT : ACCUM;
                end
            end
            RESULT: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE, ACCUM: in_ready  = 1'b1;
            RESULT:      out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sect_cnt <= '0;
            acc      <= '0;
            low_flag <= 1'b0;
        end else if (out_xfer) begin
            sect_cnt <= '0;
            acc      <= '0;
            low_flag <= 1'b0;
        end else if (grade_xfer) begin
            sect_cnt <= sect_cnt + CW'(1);
            acc      <= acc_next;
            low_flag <= low_next;
        end
    end

    // result registers hold after the handshake; out_valid qualifies them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_total         <= '0;
            failed            <= 1'b0;
            passed            <= 1'b0;
            award_scholarship <= 1'b0;
        end else if (grade_xfer && last_grade) begin
            out_total         <= acc_next;
            failed            <= fail_next;
            passed            <= ~fail_next;
            award_scholarship <= award_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_students <= '0;
            stat_passed   <= '0;
            stat_awards   <= '0;
        end else if (stat_clear) begin
            stat_students <= '0;
            stat_passed   <= '0;
            stat_awards   <= '0;
        end else if (out_xfer) begin
            if (stat_students != '1) begin
                stat_students <= stat_students + CNT_W'(1);
            end
            if (passed && stat_passed != '1) begin
                stat_passed <= stat_passed + CNT_W'(1);
            end
            if (award_scholarship && stat_awards != '1) begin
                stat_awards <= stat_awards + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_grade_evaluator.sv
// Directed bench: a default evaluator and one with MIN_SECT=30 / CNT_W=2 share
// the same stimulus and are checked against hand-computed results.
module tb_grade_evaluator;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_grade;
    logic       out_ready;
    logic       stat_clear;

    logic        a_in_ready, a_out_valid, a_failed, a_passed, a_award;
    logic [9:0]  a_out_total;
    logic [15:0] a_students, a_npassed, a_awards;

    logic        b_in_ready, b_out_valid, b_failed, b_passed, b_award;
    logic [9:0]  b_out_total;
    logic [1:0]  b_students, b_npassed, b_awards;

    int checks   = 0;
    int failures = 0;

    grade_evaluator dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_grade(in_grade),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_total(a_out_total),
        .failed(a_failed), .passed(a_passed), .award_scholarship(a_award),
        .stat_clear(stat_clear), .stat_students(a_students),
        .stat_passed(a_npassed), .stat_awards(a_awards)
    );

    grade_evaluator #(.MIN_SECT(30), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_grade(in_grade),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_total(b_out_total),
        .failed(b_failed), .passed(b_passed), .award_scholarship(b_award),
        .stat_clear(stat_clear), .stat_students(b_students),
        .stat_passed(b_npassed), .stat_awards(b_awards)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0][7:0] g;
        int              total;
        logic            a_fail;
        logic            a_award;
        logic            b_fail;
        logic            b_award;
    } vec_t;

    vec_t vecs [8];

    function automatic vec_t mk(input logic [7:0] g0, input logic [7:0] g1,
                                input logic [7:0] g2, input logic [7:0] g3,
                                input int total, input logic af, input logic aa,
                                input logic bf, input logic ba);
        vec_t v;
        v.g[0] = g0; v.g[1] = g1; v.g[2] = g2; v.g[3] = g3;
        v.total = total; v.a_fail = af; v.a_award = aa; v.b_fail = bf; v.b_award = ba;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0][7:0] g);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_grade = g[i];
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("out_valid_after_hs", 32'(a_out_valid), 0);
    endtask

    initial begin
        vecs[0] = mk(25, 25, 25, 24,   99, 1, 0, 1, 0);
        vecs[1] = mk(25, 25, 25, 25,  100, 0, 0, 1, 0);
        vecs[2] = mk(50, 50, 50, 49,  199, 0, 0, 0, 0);
        vecs[3] = mk(50, 50, 50, 50,  200, 0, 1, 0, 1);
        vecs[4] = mk(255, 255, 255, 255, 1020, 0, 1, 0, 1);
        vecs[5] = mk(255, 255, 255, 29, 794, 0, 1, 1, 0);
        vecs[6] = mk(30, 30, 30, 30,  120, 0, 0, 0, 0);
        vecs[7] = mk(0, 0, 0, 0,        0, 1, 0, 1, 0);

        rst = 1'b1; in_valid = 1'b0; in_grade = '0; out_ready = 1'b0; stat_clear = 1'b0;
        #3;
        chk("reset_out_valid", 32'(a_out_valid), 0);
        chk("reset_out_total", 32'(a_out_total), 0);
        chk("reset_flags", {29'd0, a_failed, a_passed, a_award}, 0);
        chk("reset_students", 32'(a_students), 0);
        step();
        step();
        rst = 1'b0;
        chk("reset_in_ready", 32'(a_in_ready), 1);

        for (int k = 0; k < 8; k++) begin
            send(vecs[k].g);
            chk($sformatf("v%0d_out_valid", k), 32'(a_out_valid), 1);
            chk($sformatf("v%0d_in_ready", k), 32'(a_in_ready), 0);
            chk($sformatf("v%0d_total", k), 32'(a_out_total), 32'(vecs[k].total));
            chk($sformatf("v%0d_a_failed", k), 32'(a_failed), 32'(vecs[k].a_fail));
            chk($sformatf("v%0d_a_passed", k), 32'(a_passed), 32'(!vecs[k].a_fail));
            chk($sformatf("v%0d_a_award", k), 32'(a_award), 32'(vecs[k].a_award));
            chk($sformatf("v%0d_b_failed", k), 32'(b_failed), 32'(vecs[k].b_fail));
            chk($sformatf("v%0d_b_passed", k), 32'(b_passed), 32'(!vecs[k].b_fail));
            chk($sformatf("v%0d_b_award", k), 32'(b_award), 32'(vecs[k].b_award));
            handshake();
        end

        chk("a_students_8", 32'(a_students), 8);
        chk("a_passed_6", 32'(a_npassed), 6);
        chk("a_awards_3", 32'(a_awards), 3);
        chk("b_students_sat", 32'(b_students), 3);
        chk("b_passed_sat", 32'(b_npassed), 3);
        chk("b_awards_2", 32'(b_awards), 2);

        // backpressure: offered grades must not be taken while the result waits
        send({8'd50, 8'd50, 8'd50, 8'd50});
        in_valid = 1'b1;
        in_grade = 8'd7;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp_in_ready", 32'(a_in_ready), 0);
            chk("bp_out_valid", 32'(a_out_valid), 1);
            chk("bp_total", 32'(a_out_total), 200);
            chk("bp_award", 32'(a_award), 1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_students", 32'(a_students), 9);
        chk("bp_idle_in_ready", 32'(a_in_ready), 1);
        for (int c = 0; c < 4; c++) begin
            step();
        end
        in_valid = 1'b0;
        chk("bp_next_out_valid", 32'(a_out_valid), 1);
        chk("bp_next_total", 32'(a_out_total), 28);
        chk("bp_next_failed", 32'(a_failed), 1);
        handshake();
        chk("bp_students_10", 32'(a_students), 10);
        chk("bp_passed_7", 32'(a_npassed), 7);
        chk("bp_awards_4", 32'(a_awards), 4);

        // asynchronous reset after two grades
        in_valid = 1'b1;
        in_grade = 8'd30;
        step();
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_out_total", 32'(a_out_total), 0);
        chk("arst_failed", 32'(a_failed), 0);
        chk("arst_students", 32'(a_students), 0);
        chk("arst_out_valid", 32'(a_out_valid), 0);
        step();
        rst = 1'b0;
        send({8'd30, 8'd30, 8'd30, 8'd30});
        chk("arst_new_valid", 32'(a_out_valid), 1);
        chk("arst_new_total", 32'(a_out_total), 120);
        chk("arst_new_passed", 32'(a_passed), 1);
        handshake();
        chk("arst_new_students", 32'(a_students), 1);

        // clear wins over a same-cycle handshake
        send({8'd10, 8'd10, 8'd10, 8'd10});
        chk("clr_total", 32'(a_out_total), 40);
        out_ready = 1'b1;
        stat_clear = 1'b1;
        step();
        out_ready = 1'b0;
        stat_clear = 1'b0;
        chk("clr_out_valid", 32'(a_out_valid), 0);
        chk("clr_a_students", 32'(a_students), 0);
        chk("clr_b_students", 32'(b_students), 0);
        chk("clr_b_passed", 32'(b_npassed), 0);
        step();
        chk("clr_a_students_hold", 32'(a_students), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
